// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC with valid/ready handshake, trap/redirect/return
// arbitration, misaligned-target detection and a circular return-address stack.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     IALIGN       = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call_valid,
  input  logic [XLEN-1:0] link_addr,
  input  logic            ret_valid,
  input  logic            trap_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned     PtrW      = $clog2(RAS_DEPTH);
  localparam int unsigned     CntW      = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] AlignMask = XLEN'(IALIGN - 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_valid_q;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0] top_q, top_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, advance, target_ok;

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign misaligned  = misaligned_q;
  assign bad_addr    = bad_addr_q;
  assign ras_empty   = (count_q == '0);
  assign ras_full    = (count_q == CntMax);
  assign pc_next_seq = pc_q + XLEN'(IALIGN);
  assign advance     = fetch_valid_q & fetch_ready & ~stall;
  assign target_ok   = (redirect_target & AlignMask) == '0;

  // Flush sources (trap, redirect, return) take effect regardless of stall/fetch_ready.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    bad_addr_d   = bad_addr_q;
    push         = 1'b0;
    pop          = 1'b0;
    if (trap_valid) begin
      pc_d = TRAP_VECTOR;
    end else if (redirect_valid) begin
      if (target_ok) begin
        pc_d = redirect_target;
        push = call_valid;
      end else begin
        pc_d         = TRAP_VECTOR;
        misaligned_d = 1'b1;
        bad_addr_d   = redirect_target;
      end
    end else if (ret_valid && !ras_empty) begin
      pc_d = ras_q[top_q];
      pop  = 1'b1;
    end else if (advance) begin
      pc_d = pc_next_seq;
    end
  end

  // A push into a full stack overwrites the oldest entry; count saturates.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    if (push) begin
      top_d = top_q + PtrW'(1);
      if (!ras_full) count_d = count_q + CntW'(1);
    end else if (pop) begin
      top_d   = top_q - PtrW'(1);
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bad_addr_q    <= '0;
      top_q         <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_valid_q <= 1'b1;
      misaligned_q  <= misaligned_d;
      bad_addr_q    <= bad_addr_d;
      top_q         <= top_d;
      count_q       <= count_d;
    end
  end

  // Stack contents survive reset; only the count/pointer are cleared.
  always_ff @(posedge clock) begin
    if (push) ras_q[top_d] <= link_addr;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit: next generation of the core's bare PC register.
- Holds the fetch PC and drives the instruction-fetch address with a valid/ready handshake. Honours stall.
- Arbitrates trap, branch/jump redirect and return redirects, and detects misaligned targets.
- Keeps a small circular return-address stack (RAS) for call/return prediction.
- Sits between decode/execute (redirect sources) and instruction memory.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect.
- IALIGN, 4, instruction alignment and sequential increment in bytes; legal values 2 or 4.
- RAS_DEPTH, 4, return-address-stack entries; power of two, 2..16.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC (pipeline stall).
- fetch_ready  in  1  instruction memory accepts the current address.
- fetch_valid  out  1  pc is a valid fetch request.
- pc  out  XLEN  current fetch address.
- pc_next_seq  out  XLEN  pc + IALIGN (combinational, wraps modulo 2^XLEN).
- redirect_valid  in  1  branch taken / jump.
- redirect_target  in  XLEN  redirect destination.
- call_valid  in  1  redirect is a call; push link_addr (qualified by redirect_valid).
- link_addr  in  XLEN  return address to push.
- ret_valid  in  1  return; take RAS top as target.
- trap_valid  in  1  exception/interrupt; go to TRAP_VECTOR.
- misaligned  out  1  one-cycle pulse: rejected misaligned redirect target.
- bad_addr  out  XLEN  last misaligned target, held until next misaligned event.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (async, any time, including mid-operation): pc=RESET_VECTOR, fetch_valid=0, misaligned=0, bad_addr=0, RAS count=0, top pointer=0; ras_empty=1, ras_full=0.
- fetch_valid goes 1 on the first rising edge after reset deasserts, then stays 1.
- advance = fetch_valid & fetch_ready & ~stall.
- Next-PC priority, evaluated every cycle:
  1. trap_valid → TRAP_VECTOR.
  2. redirect_valid → redirect_target, provided its low log2(IALIGN) bits are 0. Otherwise: pc=TRAP_VECTOR, misaligned=1 for that cycle, bad_addr=redirect_target, no RAS push.
  3. ret_valid & ~ras_empty → RAS top, and pop.
  4. advance → pc + IALIGN.
  5. Otherwise hold.
- Trap, redirect and ret override stall and do not wait for fetch_ready: a flush dominates a stall.
- Latency: every PC update is visible on pc one cycle after the qualifying inputs are sampled.
- ret_valid with ras_empty: no-op on RAS and PC chooses rule 4/5; no error flag.
- ret_valid together with redirect_valid or trap_valid: ret ignored, no pop.
- Push: redirect_valid & call_valid & ~trap_valid & aligned target. Stores link_addr at top+1.
  - When full, the oldest entry is overwritten (circular) and count stays RAS_DEPTH.
- Pop: top pointer −1 modulo RAS_DEPTH, count −1.
- Push and pop never occur in the same cycle (guaranteed by the priority rules above).
- trap_valid with redirect_valid/call_valid: trap wins, no push, misaligned not raised.
- PC wraps: 32'hFFFF_FFFC + 4 → 32'h0000_0000 (XLEN=32, IALIGN=4).
- RAS contents are not cleared on trap; only reset clears count.

Test Plan:
- Reset release, fetch_ready=1, stall=0 → fetch_valid=1 after one edge. pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Hold pc=0x40 with stall=1 for 3 cycles, assert redirect_valid target 0x200 during the stall → next pc=0x200 despite stall. Also fetch_ready=0 holds pc at 0x204 until it returns to 1.
- Call to 0x300 with link_addr 0x104, then ret_valid → pc=0x300 then pc=0x104; ras_empty 0→1. Push 5 calls (RAS_DEPTH=4) then 5 rets → targets are the last 4 links in LIFO order; 5th ret falls to sequential.
- redirect_target=0x202, IALIGN=4 → pc=0x100, misaligned pulses 1 cycle, bad_addr=0x202, RAS unchanged. With IALIGN=2 the same target is accepted.
- trap_valid + redirect_valid(0x500) + call_valid same cycle → pc=0x100, no push, misaligned=0.
- pc=0xFFFF_FFFC advancing → 0x0000_0000. Assert reset mid-stream → pc=0x0 immediately (before the clock edge), fetch_valid=0, ras_empty=1.
